spi_frame_sequencer: RTL
========================

# spi_frame_sequencer

Controller between the SPI byte receiver and the digit-recognizer core. Decodes the received byte stream into pixel and label frames, streams pixel bytes into the image buffer with generated addresses, and starts inference once the image is complete. It gates the cost calculation on a matching label, and protects the image buffer from being overwritten while the network is running.

## Interface
- NUM_PIXELS, 72: pixel bytes per image frame (≥2).
- ADDR_W, 7: image buffer address width; NUM_PIXELS ≤ 2^ADDR_W.
- NUM_CLASSES, 10: label classes; width of the one-hot label.
- clk  in  1  system clock
- rst  in  1  reset: synchronous, active-high
- byte_valid  in  1  one-cycle strobe: a new SPI byte is on byte_data
- byte_data  in  8  received SPI byte
- frame_abort  in  1  one-cycle pulse on SS deassertion; terminates the current frame
- net_busy  in  1  network core is computing
- net_done  in  1  one-cycle pulse when the network has finished
- pix_we  out  1  image buffer write enable
- pix_addr  out  ADDR_W  image buffer write address
- pix_data  out  8  image buffer write data
- start_inference  out  1  one-cycle pulse to start the network
- calculate_cost  out  1  one-cycle pulse to start the cost stage
- expected_label  out  NUM_CLASSES  one-hot target label
- overrun  out  1  sticky: a frame was dropped because the network was busy
- bad_frame  out  1  sticky: bad header, bad label, or (if enabled) checksum error
- clear_flags  in  1  clears overrun and bad_frame

## Operation
- States: IDLE, PIX, LBL, START, WAIT_NET, DROP.
- IDLE: the first byte_valid is the header.
  - 0x00 → PIX, address counter cleared.
  - 0x01 → LBL.
  - Any other value → DROP, bad_frame set.
  - 0x00 while net_busy, or while in WAIT_NET → DROP, overrun set; the buffer is untouched.
- PIX: each byte_valid writes byte_data to address cnt, then cnt increments. After byte NUM_PIXELS-1 → START.
- START: start_inference pulses for one cycle → WAIT_NET.
- WAIT_NET: stays until net_done → IDLE with img_ready set. Label frames are accepted during WAIT_NET; the state machine runs LBL and returns to WAIT_NET.
- LBL: one byte.
  - If the value is < NUM_CLASSES: expected_label ← one-hot(value) and lbl_ready is set.
  - Otherwise bad_frame is set and expected_label is unchanged.
  - Returns to IDLE, or to WAIT_NET if the network is still running.
- Cost launch: when img_ready and lbl_ready are both set, calculate_cost pulses once and both flags clear.
- DROP: ignores bytes until frame_abort → IDLE.
- frame_abort in any state → IDLE (or WAIT_NET if inference is running). A partial PIX frame leaves written bytes in the buffer but never starts inference.
- Simultaneous events: frame_abort wins over a byte_valid in the same cycle. clear_flags loses to a same-cycle flag set.

## Timing
- Registered outputs. pix_we, pix_addr and pix_data are valid the cycle after byte_valid, and pix_we is high for one cycle.
- start_inference is asserted 2 cycles after the last pixel byte_valid.
- calculate_cost is asserted the cycle after both ready flags are set.
- Minimum byte_valid spacing is 2 cycles.
- Reset values: every output 0, expected_label 0, counters 0, state IDLE, img_ready = lbl_ready = 0.
- The address counter never wraps past NUM_PIXELS-1; it resets at every header.

## Configuration
- SPI_SEQ_CHECKSUM_EN defined:
  - Pixel frames carry one extra byte after the pixels: the 8-bit modulo-256 sum of all pixel bytes.
  - START is entered only on a match.
  - On a mismatch: bad_frame is set, state → IDLE, no start_inference.
- Not defined: no trailing byte; START is entered directly after the last pixel.

## Structure
- Shared package spi_seq_pkg holds the state enum, the header constants HDR_PIXEL = 8'h00 and HDR_LABEL = 8'h01, and the default NUM_PIXELS / NUM_CLASSES.
- One sub-module: flex_counter (existing) as the pixel address counter, with clear on header and count_enable on accepted pixel writes.

## Test plan
- Header 0x00 plus 72 bytes 0..71 → 72 pix_we pulses at addresses 0..71 with data equal to address; start_inference exactly once, 2 cycles after byte 71.
- Header 0x01, byte 0x03, after net_done of a completed image → expected_label = 10'b0000001000; calculate_cost one pulse.
- Header 0x01, byte 0x0C → bad_frame = 1; expected_label unchanged; no calculate_cost.
- Header 0x00 while net_busy = 1 → overrun = 1; zero pix_we; frame_abort returns the FSM to IDLE.
- frame_abort after 30 pixel bytes → no start_inference; the next full frame writes starting at address 0.
- With SPI_SEQ_CHECKSUM_EN: 72 bytes of 0x01 followed by 0x48 → start_inference; followed by 0x47 → bad_frame, no start_inference.

Source files
------------

// File: rtl/spi_seq_pkg.sv
// Shared definitions for the SPI frame sequencer: FSM state encoding,
// frame header bytes and default geometry of the image / label frames.
package spi_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PIX      = 3'd1,
        ST_LBL      = 3'd2,
        ST_START    = 3'd3,
        ST_WAIT_NET = 3'd4,
        ST_DROP     = 3'd5
    } seq_state_t;

    localparam logic [7:0] HDR_PIXEL = 8'h00;
    localparam logic [7:0] HDR_LABEL = 8'h01;

    localparam int DEF_NUM_PIXELS  = 72;
    localparam int DEF_NUM_CLASSES = 10;
    localparam int DEF_ADDR_W      = 7;

endpackage

// File: rtl/flex_counter.sv
// Up-counter with synchronous clear and count enable. It saturates at
// max_val instead of wrapping, so an address generator built on it can never
// step past the last valid location.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] max_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    at_max
);

    logic [NUM_CNT_BITS-1:0] count_reg;

    // Count register: clear has priority, then a saturating increment.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
        end else if (count_enable && (count_reg != max_val)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count_out = count_reg;
    assign at_max    = (count_reg == max_val);

endmodule

// File: rtl/spi_frame_sequencer.sv
// Decodes the SPI byte stream into pixel / label frames, streams pixels into
// the image buffer, launches inference on a complete image and launches the
// cost stage once both an image result and a valid label are available.
// Optional feature macro: SPI_SEQ_CHECKSUM_EN -- pixel frames carry a trailing
// modulo-256 sum byte and inference starts only when it matches.
module spi_frame_sequencer
    import spi_seq_pkg::*;
#(
    parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_CLASSES = DEF_NUM_CLASSES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    input  logic                   frame_abort,
    input  logic                   net_busy,
    input  logic                   net_done,
    output logic                   pix_we,
    output logic [ADDR_W-1:0]      pix_addr,
    output logic [7:0]             pix_data,
    output logic                   start_inference,
    output logic                   calculate_cost,
    output logic [NUM_CLASSES-1:0] expected_label,
    output logic                   overrun,
    output logic                   bad_frame,
    input  logic                   clear_flags
);

    localparam logic [ADDR_W-1:0] LAST_ADDR   = ADDR_W'(NUM_PIXELS - 1);
    localparam logic [7:0]        CLASS_LIMIT = 8'(NUM_CLASSES);

    seq_state_t             state_reg, state_next;
    logic                   infer_active_reg, infer_active_next;
    logic                   img_ready_reg, img_ready_next;
    logic                   lbl_ready_reg, lbl_ready_next;
    logic                   pix_we_reg, pix_we_next;
    logic [ADDR_W-1:0]      pix_addr_reg, pix_addr_next;
    logic [7:0]             pix_data_reg, pix_data_next;
    logic                   start_reg, start_next;
    logic                   cost_reg, cost_next;
    logic [NUM_CLASSES-1:0] label_reg, label_next;
    logic                   overrun_reg, overrun_next;
    logic                   bad_reg, bad_next;
`ifdef SPI_SEQ_CHECKSUM_EN
    logic [7:0]             sum_reg, sum_next;
    logic                   sum_phase_reg, sum_phase_next;
`endif

    logic                   cnt_clear, cnt_en, cnt_at_last;
    logic [ADDR_W-1:0]      cnt;
    logic                   byte_ok, net_running, launch;
    logic                   set_overrun, set_bad, set_img, set_lbl;
    seq_state_t             return_state;
    logic [NUM_CLASSES-1:0] label_onehot;

    // A same-cycle frame_abort discards the byte.
    assign byte_ok      = byte_valid & ~frame_abort;
    // Inference still running after this cycle.
    assign net_running  = infer_active_reg & ~net_done;
    assign return_state = net_running ? ST_WAIT_NET : ST_IDLE;
    assign launch       = img_ready_reg & lbl_ready_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CLASSES; gi++) begin : g_onehot
            assign label_onehot[gi] = (byte_data == 8'(gi));
        end
    endgenerate

    flex_counter #(
        .NUM_CNT_BITS (ADDR_W)
    ) u_addr_cnt (
        .clk          (clk),
        .rst          (rst),
        .clear        (cnt_clear),
        .count_enable (cnt_en),
        .max_val      (LAST_ADDR),
        .count_out    (cnt),
        .at_max       (cnt_at_last)
    );

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            infer_active_reg <= 1'b0;
            img_ready_reg    <= 1'b0;
            lbl_ready_reg    <= 1'b0;
            pix_we_reg       <= 1'b0;
            pix_addr_reg     <= '0;
            pix_data_reg     <= '0;
            start_reg        <= 1'b0;
            cost_reg         <= 1'b0;
            label_reg        <= '0;
            overrun_reg      <= 1'b0;
            bad_reg          <= 1'b0;
`ifdef SPI_SEQ_CHECKSUM_EN
            sum_reg          <= '0;
            sum_phase_reg    <= 1'b0;
`endif
        end else begin
            state_reg        <= state_next;
            infer_active_reg <= infer_active_next;
            img_ready_reg    <= img_ready_next;
            lbl_ready_reg    <= lbl_ready_next;
            pix_we_reg       <= pix_we_next;
            pix_addr_reg     <= pix_addr_next;
            pix_data_reg     <= pix_data_next;
            start_reg        <= start_next;
            cost_reg         <= cost_next;
            label_reg        <= label_next;
            overrun_reg      <= overrun_next;
            bad_reg          <= bad_next;
`ifdef SPI_SEQ_CHECKSUM_EN
            sum_reg          <= sum_next;
            sum_phase_reg    <= sum_phase_next;
`endif
        end
    end

    // Next-state decode, buffer write generation and flag bookkeeping.
    always_comb begin
        state_next        = state_reg;
        infer_active_next = infer_active_reg;
        pix_we_next       = 1'b0;
        pix_addr_next     = pix_addr_reg;
        pix_data_next     = pix_data_reg;
        start_next        = 1'b0;
        label_next        = label_reg;
        cnt_clear         = 1'b0;
        cnt_en            = 1'b0;
        set_overrun       = 1'b0;
        set_bad           = 1'b0;
        set_img           = 1'b0;
        set_lbl           = 1'b0;
`ifdef SPI_SEQ_CHECKSUM_EN
        sum_next          = sum_reg;
        sum_phase_next    = sum_phase_reg;
`endif

        // Completion is recorded whatever state the byte decoder is in.
        if (infer_active_reg && net_done) begin
            infer_active_next = 1'b0;
            set_img           = 1'b1;
        end

        case (state_reg)
            ST_IDLE: begin
                if (byte_ok) begin
                    if (byte_data == HDR_PIXEL) begin
                        if (net_busy) begin
                            state_next  = ST_DROP;
                            set_overrun = 1'b1;
                        end else begin
                            state_next = ST_PIX;
                            cnt_clear  = 1'b1;
`ifdef SPI_SEQ_CHECKSUM_EN
                            sum_next       = '0;
                            sum_phase_next = 1'b0;
`endif
                        end
                    end else if (byte_data == HDR_LABEL) begin
                        state_next = ST_LBL;
                    end else begin
                        state_next = ST_DROP;
                        set_bad    = 1'b1;
                    end
                end
            end

            ST_PIX: begin
                if (frame_abort) begin
                    state_next = return_state;
                end else if (byte_valid) begin
`ifdef SPI_SEQ_CHECKSUM_EN
                    if (sum_phase_reg) begin
                        if (byte_data == sum_reg) begin
                            state_next = ST_START;
                        end else begin
                            state_next = ST_IDLE;
                            set_bad    = 1'b1;
                        end
                    end else begin
                        pix_we_next   = 1'b1;
                        pix_addr_next = cnt;
                        pix_data_next = byte_data;
                        cnt_en        = 1'b1;
                        sum_next      = sum_reg + byte_data;
                        if (cnt_at_last) begin
                            sum_phase_next = 1'b1;
                        end
                    end
`else
                    pix_we_next   = 1'b1;
                    pix_addr_next = cnt;
                    pix_data_next = byte_data;
                    cnt_en        = 1'b1;
                    if (cnt_at_last) begin
                        state_next = ST_START;
                    end
`endif
                end
            end

            ST_LBL: begin
                if (frame_abort) begin
                    state_next = return_state;
                end else if (byte_valid) begin
                    if (byte_data < CLASS_LIMIT) begin
                        label_next = label_onehot;
                        set_lbl    = 1'b1;
                    end else begin
                        set_bad = 1'b1;
                    end
                    state_next = return_state;
                end
            end

            // The image is complete, so a trailing abort (SS release) must not
            // cancel the launch.
            ST_START: begin
                start_next        = 1'b1;
                infer_active_next = 1'b1;
                state_next        = ST_WAIT_NET;
            end

            ST_WAIT_NET: begin
                if (frame_abort) begin
                    state_next = return_state;
                end else if (byte_ok) begin
                    if (byte_data == HDR_LABEL) begin
                        state_next = ST_LBL;
                    end else if (byte_data == HDR_PIXEL) begin
                        state_next  = ST_DROP;
                        set_overrun = 1'b1;
                    end else begin
                        state_next = ST_DROP;
                        set_bad    = 1'b1;
                    end
                end else if (!net_running) begin
                    state_next = ST_IDLE;
                end
            end

            ST_DROP: begin
                if (frame_abort) begin
                    state_next = return_state;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase

        // Sticky flags: a same-cycle set beats clear_flags.
        overrun_next   = set_overrun | (overrun_reg & ~clear_flags);
        bad_next       = set_bad | (bad_reg & ~clear_flags);
        // Ready flags: a same-cycle set survives the launch clear.
        img_ready_next = set_img | (img_ready_reg & ~launch);
        lbl_ready_next = set_lbl | (lbl_ready_reg & ~launch);
        cost_next      = launch;
    end

    assign pix_we          = pix_we_reg;
    assign pix_addr        = pix_addr_reg;
    assign pix_data        = pix_data_reg;
    assign start_inference = start_reg;
    assign calculate_cost  = cost_reg;
    assign expected_label  = label_reg;
    assign overrun         = overrun_reg;
    assign bad_frame       = bad_reg;

endmodule
